nic_ring_stop: RTL and testbench

- Parametrised ring-network stop for the SoC packet NIC.
- Generalises the fixed 32-bit packet format to AWID/DWID widths. Adds a local transmit queue, a single-entry receive holding register, broadcast delivery, and age-based removal of undeliverable packets.
- One stop sits per node on a unidirectional ring. The output of each stop is registered and feeds the next stop's ring input.

---
 rtl/nic_ring_stop.sv | 173 +++++++++++++++++
 tb/tb_nic_ring_stop.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nic_ring_stop.sv
// nic_ring_stop: one stop on a unidirectional packet ring.
// Each cycle the incoming slot is either delivered locally, removed
// (completed broadcast or aged-out packet), or forwarded with its age
// incremented. A freed or empty slot is refilled from the local transmit
// queue. The ring output, receive holding register and drop pulse are all
// registered.
module nic_ring_stop #(
    parameter logic [5:0] ID        = 6'd1,
    parameter int         AWID      = 32,
    parameter int         DWID      = 32,
    parameter int         TXQ_DEPTH = 4,
    parameter logic [5:0] MAX_AGE   = 6'd32,
    parameter int         PW        = 28 + DWID/8 + AWID + DWID
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [PW-1:0]                rpkt_i,
    output logic [PW-1:0]                rpkt_o,
    input  logic                         tx_valid_i,
    output logic                         tx_ready_o,
    input  logic [PW-1:0]                tx_pkt_i,
    output logic                         rx_valid_o,
    input  logic                         rx_ready_i,
    output logic [PW-1:0]                rx_pkt_o,
    output logic [$clog2(TXQ_DEPTH):0]   txq_count_o,
    output logic                         dropped_o
);

    localparam int SELW    = DWID / 8;
    // Field positions, counted from the LSB (dat sits at bit 0).
    localparam int TYP_LSB = DWID + AWID + SELW + 3;   // above we and pad2
    localparam int AGE_LSB = TYP_LSB + 7;              // above typ and ack
    localparam int SID_LSB = AGE_LSB + 6;
    localparam int DID_LSB = SID_LSB + 6;

    localparam int PTRW = $clog2(TXQ_DEPTH);
    localparam int CW   = PTRW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(TXQ_DEPTH);

    localparam logic [5:0] PT_NULL = 6'd0;
    localparam logic [5:0] BCAST   = 6'h3F;
    localparam logic [5:0] AGE_TOP = 6'h3F;

    // Age increment saturating at the top of the 6-bit field.
    function automatic logic [5:0] age_sat_inc(input logic [5:0] a);
        return (a == AGE_TOP) ? a : a + 6'd1;
    endfunction

    // Rewrite the sid and age fields of a packet, leaving everything else.
    function automatic logic [PW-1:0] set_sid_age(input logic [PW-1:0] p,
                                                  input logic [5:0]    sid,
                                                  input logic [5:0]    age);
        logic [PW-1:0] r;
        r = p;
        r[SID_LSB +: 6] = sid;
        r[AGE_LSB +: 6] = age;
        return r;
    endfunction

    logic [PW-1:0]   rpkt_q, rpkt_d;
    logic            rx_valid_q, rx_valid_d;
    logic [PW-1:0]   rx_pkt_q, rx_pkt_d;
    logic            dropped_q;
    logic [PTRW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   txq_mem_q [TXQ_DEPTH];

    logic [5:0] in_did, in_sid, in_age, in_typ;
    logic       slot_occ, rx_free;
    logic       fwd, cap, drop;
    logic       push, pop;
    logic [PW-1:0] fwd_pkt, inj_pkt;

    assign in_did   = rpkt_i[DID_LSB +: 6];
    assign in_sid   = rpkt_i[SID_LSB +: 6];
    assign in_age   = rpkt_i[AGE_LSB +: 6];
    assign in_typ   = rpkt_i[TYP_LSB +: 6];
    assign slot_occ = (in_typ != PT_NULL);
    assign rx_free  = !rx_valid_q || rx_ready_i;

    assign fwd_pkt  = set_sid_age(rpkt_i, in_sid, age_sat_inc(in_age));
    assign inj_pkt  = set_sid_age(txq_mem_q[rd_ptr_q], ID, 6'd0);

    assign tx_ready_o = (cnt_q != DEPTH_C);
    assign push       = tx_valid_i && tx_ready_o;
    // The slot can take a local packet whenever nothing is being forwarded.
    assign pop        = !fwd && (cnt_q != '0);

    // Slot decision for the incoming packet, in priority order.
    always_comb begin
        fwd  = 1'b0;
        cap  = 1'b0;
        drop = 1'b0;
        if (slot_occ) begin
            if (in_did == ID) begin
                if (rx_free) cap = 1'b1;
                else         fwd = 1'b1;
            end else if (in_did == BCAST) begin
                // A broadcast back at its source has visited every stop.
                if (in_sid != ID) begin
                    cap = rx_free;
                    fwd = 1'b1;
                end
            end else if ((in_sid == ID) && (in_age >= MAX_AGE)) begin
                drop = 1'b1;
            end else begin
                fwd = 1'b1;
            end
        end
    end

    // Next ring output: injection wins the free slot, else forward, else null.
    always_comb begin
        rpkt_d = '0;
        if (pop)      rpkt_d = inj_pkt;
        else if (fwd) rpkt_d = fwd_pkt;
    end

    // Receive holding register next state; capture and take may coincide.
    always_comb begin
        rx_valid_d = rx_valid_q;
        rx_pkt_d   = rx_pkt_q;
        if (cap) begin
            rx_valid_d = 1'b1;
            rx_pkt_d   = rpkt_i;
        end else if (rx_ready_i) begin
            rx_valid_d = 1'b0;
        end
    end

    // Queue occupancy next state.
    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Queue storage; contents are don't-care while the count says empty.
    always_ff @(posedge clk_i) begin
        if (push) txq_mem_q[wr_ptr_q] <= tx_pkt_i;
    end

    // Control and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rpkt_q     <= '0;
            rx_valid_q <= 1'b0;
            rx_pkt_q   <= '0;
            dropped_q  <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            rpkt_q     <= rpkt_d;
            rx_valid_q <= rx_valid_d;
            rx_pkt_q   <= rx_pkt_d;
            dropped_q  <= drop;
            cnt_q      <= cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTRW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTRW'(1);
        end
    end

    assign rpkt_o      = rpkt_q;
    assign rx_valid_o  = rx_valid_q;
    assign rx_pkt_o    = rx_pkt_q;
    assign txq_count_o = cnt_q;
    assign dropped_o   = dropped_q;

endmodule

// File: tb/tb_nic_ring_stop.sv
// Bench for nic_ring_stop at default parameters (ID 1, 96-bit packets,
// 4-deep transmit queue). A queue-based reference model predicts every
// output each cycle; directed sequences cover the listed scenarios and a
// random phase follows.
module tb_nic_ring_stop;

    localparam int         PW      = 96;
    localparam int         DEPTH   = 4;
    localparam logic [5:0] MY_ID   = 6'd1;
    localparam logic [5:0] PT_READ = 6'd1;
    localparam logic [5:0] PT_WR   = 6'd2;

    typedef struct packed {
        logic [5:0]  did;
        logic [5:0]  sid;
        logic [5:0]  age;
        logic        ack;
        logic [5:0]  typ;
        logic [1:0]  pad2;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
    } pkt_t;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic [PW-1:0] rpkt_i, rpkt_o, tx_pkt_i, rx_pkt_o;
    logic          tx_valid_i, tx_ready_o, rx_valid_o, rx_ready_i, dropped_o;
    logic [2:0]    txq_count_o;

    nic_ring_stop dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .rpkt_i      (rpkt_i),
        .rpkt_o      (rpkt_o),
        .tx_valid_i  (tx_valid_i),
        .tx_ready_o  (tx_ready_o),
        .tx_pkt_i    (tx_pkt_i),
        .rx_valid_o  (rx_valid_o),
        .rx_ready_i  (rx_ready_i),
        .rx_pkt_o    (rx_pkt_o),
        .txq_count_o (txq_count_o),
        .dropped_o   (dropped_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state.
    pkt_t txq[$];
    pkt_t m_rpkt;
    logic m_rxv;
    pkt_t m_rxp;
    logic m_drop;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic pkt_t mk(input logic [5:0] did, input logic [5:0] sid,
                                input logic [5:0] age, input logic [5:0] typ,
                                input logic [31:0] adr, input logic [31:0] dat);
        pkt_t p;
        p      = '0;
        p.did  = did;
        p.sid  = sid;
        p.age  = age;
        p.typ  = typ;
        p.we   = (typ == PT_WR);
        p.sel  = 4'hF;
        p.adr  = adr;
        p.dat  = dat;
        return p;
    endfunction

    function automatic pkt_t rand_pkt();
        pkt_t p;
        int   r;
        p = {$urandom, $urandom, $urandom};
        r = $urandom_range(0, 9);
        if (r < 3)      p.did = MY_ID;
        else if (r < 5) p.did = 6'd63;
        r = $urandom_range(0, 9);
        if (r < 4) p.sid = MY_ID;
        r = $urandom_range(0, 9);
        if (r < 4) p.age = 6'(30 + $urandom_range(0, 3));
        else if (r == 4) p.age = 6'd63;
        if ($urandom_range(0, 9) < 3) p.typ = 6'd0;
        return p;
    endfunction

    function automatic void model_reset();
        txq.delete();
        m_rpkt = '0;
        m_rxv  = 1'b0;
        m_rxp  = '0;
        m_drop = 1'b0;
    endfunction

    // One clock of the ring-stop rules applied to the inputs now presented.
    function automatic void model_step(input pkt_t rin, input logic txv,
                                       input pkt_t txp, input logic rxr);
        logic rdy, rxfree, fwd, cap, drop;
        pkt_t out;
        rdy    = (txq.size() != DEPTH);
        rxfree = !m_rxv || rxr;
        fwd = 1'b0; cap = 1'b0; drop = 1'b0;
        if (rin.typ != 6'd0) begin
            if (rin.did == MY_ID) begin
                if (rxfree) cap = 1'b1; else fwd = 1'b1;
            end else if (rin.did == 6'd63) begin
                if (rin.sid != MY_ID) begin cap = rxfree; fwd = 1'b1; end
            end else if (rin.sid == MY_ID && rin.age >= 6'd32) begin
                drop = 1'b1;
            end else begin
                fwd = 1'b1;
            end
        end
        out = '0;
        if (!fwd && txq.size() > 0) begin
            out     = txq.pop_front();
            out.sid = MY_ID;
            out.age = 6'd0;
        end else if (fwd) begin
            out = rin;
            if (out.age < 6'd63) out.age = out.age + 6'd1;
        end
        if (cap) begin
            m_rxv = 1'b1;
            m_rxp = rin;
        end else if (rxr) begin
            m_rxv = 1'b0;
        end
        if (txv && rdy) txq.push_back(txp);
        m_rpkt = out;
        m_drop = drop;
    endfunction

    task automatic compare_all();
        chk("rpkt_o", 128'(rpkt_o), 128'(m_rpkt));
        chk("rx_valid_o", 128'(rx_valid_o), 128'(m_rxv));
        if (m_rxv) chk("rx_pkt_o", 128'(rx_pkt_o), 128'(m_rxp));
        chk("txq_count_o", 128'(txq_count_o), 128'(txq.size()));
        chk("tx_ready_o", 128'(tx_ready_o), 128'(txq.size() != DEPTH));
        chk("dropped_o", 128'(dropped_o), 128'(m_drop));
    endtask

    // Present inputs, advance the model and the DUT one clock, then compare.
    task automatic step(input pkt_t rin, input logic txv, input pkt_t txp, input logic rxr);
        rpkt_i     = rin;
        tx_valid_i = txv;
        tx_pkt_i   = txp;
        rx_ready_i = rxr;
        model_step(rin, txv, txp, rxr);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    pkt_t o, busy, nul;

    initial begin
        rst_ni     = 1'b0;
        rpkt_i     = '0;
        tx_valid_i = 1'b0;
        tx_pkt_i   = '0;
        rx_ready_i = 1'b0;
        model_reset();
        nul  = '0;
        busy = mk(6'd5, 6'd2, 6'd0, PT_READ, 32'h2000, 32'h0);
        repeat (2) @(negedge clk);
        chk("rst_rpkt", 128'(rpkt_o), 128'(0));
        chk("rst_rx_valid", 128'(rx_valid_o), 128'(0));
        chk("rst_rx_pkt", 128'(rx_pkt_o), 128'(0));
        chk("rst_count", 128'(txq_count_o), 128'(0));
        chk("rst_ready", 128'(tx_ready_o), 128'(1));
        chk("rst_dropped", 128'(dropped_o), 128'(0));
        rst_ni = 1'b1;

        // Pass-through.
        step(mk(6'd5, 6'd2, 6'd3, PT_READ, 32'h1000, 32'h0), 1'b0, nul, 1'b0);
        o = rpkt_o;
        chk("pass_age", 128'(o.age), 128'(4));
        chk("pass_did", 128'(o.did), 128'(5));
        chk("pass_adr", 128'(o.adr), 128'(32'h1000));

        // Local delivery, then a second packet while the first is held.
        step(mk(6'd1, 6'd7, 6'd0, PT_WR, 32'h0, 32'hDEADBEEF), 1'b0, nul, 1'b0);
        o = rx_pkt_o;
        chk("deliver_valid", 128'(rx_valid_o), 128'(1));
        chk("deliver_dat", 128'(o.dat), 128'(32'hDEADBEEF));
        chk("deliver_slot", 128'(rpkt_o), 128'(0));
        step(mk(6'd1, 6'd8, 6'd5, PT_WR, 32'h0, 32'h1234), 1'b0, nul, 1'b0);
        o = rpkt_o;
        chk("held_fwd_age", 128'(o.age), 128'(6));
        chk("held_fwd_dat", 128'(o.dat), 128'(32'h1234));
        step(nul, 1'b0, nul, 1'b1);
        chk("take_valid", 128'(rx_valid_o), 128'(0));

        // Fill the queue while the ring is busy, then drain it.
        for (int i = 0; i < 4; i++)
            step(busy, 1'b1, mk(6'd9, 6'd0, 6'd17, PT_WR, 32'h0, 32'hA0 + i), 1'b0);
        chk("full_count", 128'(txq_count_o), 128'(4));
        chk("full_ready", 128'(tx_ready_o), 128'(0));
        step(busy, 1'b1, mk(6'd9, 6'd0, 6'd0, PT_WR, 32'h0, 32'hFF), 1'b0);
        chk("full_hold", 128'(txq_count_o), 128'(4));
        for (int i = 0; i < 4; i++) begin
            step(nul, 1'b0, nul, 1'b0);
            o = rpkt_o;
            chk("drain_dat", 128'(o.dat), 128'(32'hA0 + i));
            chk("drain_sid_age", 128'({o.sid, o.age}), 128'({6'd1, 6'd0}));
        end
        chk("drain_count", 128'(txq_count_o), 128'(0));

        // Aged-out removal and its just-below-threshold neighbour.
        step(mk(6'd9, 6'd1, 6'd32, PT_READ, 32'h0, 32'h0), 1'b0, nul, 1'b0);
        chk("age_drop_slot", 128'(rpkt_o), 128'(0));
        chk("age_drop_pulse", 128'(dropped_o), 128'(1));
        step(nul, 1'b0, nul, 1'b0);
        chk("age_drop_once", 128'(dropped_o), 128'(0));
        step(mk(6'd9, 6'd1, 6'd31, PT_READ, 32'h0, 32'h0), 1'b0, nul, 1'b0);
        o = rpkt_o;
        chk("age_31_fwd", 128'(o.age), 128'(32));

        // Broadcast from elsewhere, then our own broadcast returning.
        step(mk(6'd63, 6'd4, 6'd2, PT_WR, 32'h0, 32'h5555), 1'b0, nul, 1'b0);
        o = rpkt_o;
        chk("bcast_rx", 128'(rx_valid_o), 128'(1));
        chk("bcast_fwd_age", 128'(o.age), 128'(3));
        step(nul, 1'b0, nul, 1'b1);
        step(busy, 1'b1, mk(6'd9, 6'd0, 6'd0, PT_READ, 32'h0, 32'h77), 1'b0);
        step(mk(6'd63, 6'd1, 6'd5, PT_WR, 32'h0, 32'h0), 1'b0, nul, 1'b0);
        o = rpkt_o;
        chk("bcast_inject_dat", 128'(o.dat), 128'(32'h77));
        chk("bcast_inject_sid", 128'(o.sid), 128'(1));

        // Asynchronous reset with traffic pending.
        step(mk(6'd1, 6'd3, 6'd0, PT_WR, 32'h0, 32'hCAFE), 1'b0, nul, 1'b0);
        for (int i = 0; i < 3; i++)
            step(busy, 1'b1, mk(6'd9, 6'd0, 6'd0, PT_READ, 32'h0, 32'hB0 + i), 1'b0);
        chk("pre_rst_count", 128'(txq_count_o), 128'(3));
        chk("pre_rst_rx", 128'(rx_valid_o), 128'(1));
        rst_ni = 1'b0;
        #1;
        chk("async_rpkt", 128'(rpkt_o), 128'(0));
        chk("async_rx_valid", 128'(rx_valid_o), 128'(0));
        chk("async_rx_pkt", 128'(rx_pkt_o), 128'(0));
        chk("async_count", 128'(txq_count_o), 128'(0));
        chk("async_ready", 128'(tx_ready_o), 128'(1));
        chk("async_dropped", 128'(dropped_o), 128'(0));
        model_reset();
        rpkt_i     = '0;
        tx_valid_i = 1'b0;
        rx_ready_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        step(nul, 1'b0, nul, 1'b0);

        // Random traffic against the model.
        for (int n = 0; n < 2000; n++)
            step(rand_pkt(), 1'($urandom_range(0, 1)), rand_pkt(),
                 1'($urandom_range(0, 3) != 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
